brick_serial_mult: RTL and testbench
====================================

BRICK_SERIAL_MULT -- requirements
Module: brick_serial_mult

Interface
REQ-001 SHALL have parameter: ACC_W, default 16, accumulator and result width; only the value 16 is supported.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operand pair offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operand pair.
REQ-006 SHALL have port: a  input  8  activation operand.
REQ-007 SHALL have port: w  input  8  weight operand.
REQ-008 SHALL have port: prec  input  2  precision select: 00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 = treated as 8-bit.
REQ-009 SHALL have port: a_signed  input  1  a is two's complement when 1, unsigned when 0.
REQ-010 SHALL have port: w_signed  input  1  w is two's complement when 1, unsigned when 0.
REQ-011 SHALL have port: out_valid  output  1  result available.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port: p  output  ACC_W  product, sign-extended when either operand is signed, zero-extended otherwise.
REQ-014 SHALL have port: busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 Accept SHALL occur on an edge with in_valid and in_ready both high; that edge SHALL register a, w, prec, a_signed and w_signed, clear the accumulator and slice counters, and enter RUN.
REQ-018 Operands SHALL be taken from bits [2N-1:0], where N = 1, 2 or 4 slices for prec 00, 01 and 10/11 respectively; higher bits are ignored.
REQ-019 Slice k of an operand SHALL be bits [2k+1:2k]; the top slice (k = N-1) of a signed operand SHALL be signed (-2..1); every other slice SHALL be unsigned (0..3).
REQ-020 Each RUN edge SHALL add one slice product (a slice i) x (w slice j), computed as a 5-bit signed value and shifted left by 2*(i+j), into the 16-bit accumulator using modulo-2^16 arithmetic.
REQ-021 Slice order SHALL be i as the outer loop and j as the inner loop, with j incrementing fastest, from (0,0) to (N-1,N-1).
REQ-022 After N*N RUN edges the FSM SHALL enter DONE, so out_valid rises N*N edges after the accept edge (1, 4 or 16).
REQ-023 p SHALL equal the accumulator, hold stable throughout DONE, and keep its value after leaving DONE until the next accept.
REQ-024 In DONE, an edge with out_ready high SHALL return the FSM to IDLE; there is no same-cycle new accept.
REQ-025 In DONE with out_ready low, the FSM SHALL hold indefinitely.
REQ-026 in_valid SHALL be ignored outside IDLE, and out_ready SHALL be ignored outside DONE.
REQ-027 The result SHALL equal the exact mathematical product; no overflow is possible at 8x8 in 16 bits.

Reset
REQ-028 While rst is high the block SHALL asynchronously force: state IDLE, in_ready 1, out_valid 0, busy 0, p 0, accumulator 0, counters 0.
REQ-029 Reset asserted mid-RUN or in DONE SHALL abort the operation and discard the partial result; no out_valid SHALL follow.
REQ-030 After rst deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 Case 1: prec 10, a 0x80, w 0x80, both signed -> out_valid exactly 16 edges after accept, p = 0x4000.
REQ-032 Case 2: prec 10, a 0xFF, w 0xFF, both unsigned -> p = 0xFE01; repeat with a signed only -> p = 0xFF01 (-255).
REQ-033 Case 3: prec 01, a 0xF8 (low nibble -8), w 0x07, both signed -> out_valid 4 edges after accept, p = 0xFFC8 (-56).
REQ-034 Case 4: prec 00, a 2'b10 signed, w 2'b11 unsigned, upper bits 0xFC (ignored) -> out_valid 1 edge after accept, p = 0xFFFA (-6).
REQ-035 Case 5: hold out_ready low for 10 cycles in DONE with in_valid high -> p stable, in_ready 0, no second accept; raise out_ready -> IDLE on the next edge, then accept.
REQ-036 Case 6: assert rst at RUN cycle 7 of an 8-bit multiply -> immediately IDLE, p 0, out_valid 0; the following 4-bit multiply completes correctly.

Source files
------------

// File: rtl/brick_serial_mult.sv
// brick_serial_mult: bit-serial (2-bit brick) multiplier, 2/4/8-bit precision.
// The operands are split into 2-bit slices. One slice-pair product is added
// to the accumulator each RUN cycle, so a multiply takes N*N cycles
// (N = 1, 2 or 4 slices). The top slice of a signed operand is signed.
module brick_serial_mult #(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       w,
  input  logic [1:0]       prec,
  input  logic             a_signed,
  input  logic             w_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] p,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [7:0]       a_r, w_r;
  logic [1:0]       prec_r;
  logic             a_sgn, w_sgn;
  logic [ACC_W-1:0] acc;
  logic [1:0]       i_cnt, j_cnt;

  // Index of the top slice: N-1 for N = 1, 2, 4.
  logic [1:0]        n_m1;
  logic [1:0]        a_sl, w_sl;
  logic              a_top, w_top;
  logic signed [4:0] a_ext, w_ext, prod;
  logic [2:0]        pos;
  logic [ACC_W-1:0]  term;

  // Slice product for the current (i, j), placed at bit 2*(i+j).
  always_comb begin
    case (prec_r)
      2'b00:   n_m1 = 2'd0;
      2'b01:   n_m1 = 2'd1;
      default: n_m1 = 2'd3;
    endcase
    a_sl  = a_r[{i_cnt, 1'b0} +: 2];
    w_sl  = w_r[{j_cnt, 1'b0} +: 2];
    // Only the most significant slice of a signed operand carries the sign.
    a_top = a_sgn && (i_cnt == n_m1);
    w_top = w_sgn && (j_cnt == n_m1);
    a_ext = {{3{a_top & a_sl[1]}}, a_sl};
    w_ext = {{3{w_top & w_sl[1]}}, w_sl};
    // Range is -6..9, so a 5-bit signed product is exact.
    prod  = a_ext * w_ext;
    pos   = {1'b0, i_cnt} + {1'b0, j_cnt};
    term  = {{(ACC_W-5){prod[4]}}, prod} << {pos, 1'b0};
  end

  // Control FSM with registered handshake/status outputs and the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_r       <= '0;
      w_r       <= '0;
      prec_r    <= '0;
      a_sgn     <= 1'b0;
      w_sgn     <= 1'b0;
      acc       <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            w_r      <= w;
            prec_r   <= prec;
            a_sgn    <= a_signed;
            w_sgn    <= w_signed;
            acc      <= '0;
            i_cnt    <= '0;
            j_cnt    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // Wraps mod 2^ACC_W; the final sum is exact for 8x8 anyway.
          acc <= acc + term;
          if (j_cnt == n_m1) begin
            j_cnt <= '0;
            if (i_cnt == n_m1) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              i_cnt <= i_cnt + 2'd1;
            end
          end else begin
            j_cnt <= j_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  // The result is the accumulator; it holds until the next accept clears it.
  assign p = acc;

endmodule

// File: tb/tb_brick_serial_mult.sv
// Self-checking bench for brick_serial_mult: directed table, corner
// sequences (DONE stall, mid-run reset) and random ops against a model.
module tb_brick_serial_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [7:0]  a, w;
  logic [1:0]  prec;
  logic        a_signed, w_signed;
  logic        out_valid, out_ready;
  logic [15:0] p;
  logic        busy;

  int errors = 0;
  int checks = 0;

  brick_serial_mult #(.ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .w(w), .prec(prec), .a_signed(a_signed), .w_signed(w_signed),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a, w;
    logic [1:0]  prec;
    logic        as_, ws_;
    logic [15:0] exp_p;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: interpret the low 2N bits as plain integers and multiply.
  function automatic logic [15:0] model(input logic [7:0] av, input logic [7:0] wv,
                                        input logic [1:0] pr, input logic as_, input logic ws_);
    int bits, x, y, r;
    logic [15:0] res;
    bits = (pr == 2'b00) ? 2 : (pr == 2'b01) ? 4 : 8;
    x = int'(av) & ((1 << bits) - 1);
    y = int'(wv) & ((1 << bits) - 1);
    if (as_ && x >= (1 << (bits - 1))) x -= (1 << bits);
    if (ws_ && y >= (1 << (bits - 1))) y -= (1 << bits);
    r = x * y;
    res = r[15:0];
    return res;
  endfunction

  function automatic int lat_of(input logic [1:0] pr);
    return (pr == 2'b00) ? 1 : (pr == 2'b01) ? 4 : 16;
  endfunction

  // Accept one operand pair and count edges until out_valid; leaves DONE
  // pending (out_ready low) so callers can inspect or release it.
  task automatic start_and_wait(input logic [7:0] av, input logic [7:0] wv,
                                input logic [1:0] pr, input logic as_, input logic ws_,
                                output int lat);
    int g;
    @(negedge clk);
    a = av; w = wv; prec = pr; a_signed = as_; w_signed = ws_; in_valid = 1'b1;
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; w = $urandom;  // accepted operands must have been registered
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (lat >= 40) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic release_done(input int hold);
    logic [15:0] ph;
    ph = p;
    for (int k = 0; k < hold; k++) begin @(posedge clk); #1; end
    if (hold > 0) chk("p_stable_in_done", 32'(p), 32'(ph));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("idle_after_release", {30'd0, in_ready, out_valid}, 32'b10);
    chk("p_held_after_done", 32'(p), 32'(ph));
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] wv,
                        input logic [1:0] pr, input logic as_, input logic ws_,
                        input int hold, input string name);
    int lat;
    logic [15:0] e;
    e = model(av, wv, pr, as_, ws_);
    start_and_wait(av, wv, pr, as_, ws_, lat);
    chk({name, "_p"}, 32'(p), 32'(e));
    chk({name, "_lat"}, 32'(lat), 32'(lat_of(pr)));
    release_done(hold);
  endtask

  vec_t tbl[5];

  initial begin
    int lat;
    logic [15:0] ph;

    tbl[0] = '{8'h80, 8'h80, 2'b10, 1'b1, 1'b1, 16'h4000, 16};
    tbl[1] = '{8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0, 16'hFE01, 16};
    tbl[2] = '{8'hFF, 8'hFF, 2'b10, 1'b1, 1'b0, 16'hFF01, 16};
    tbl[3] = '{8'hF8, 8'h07, 2'b01, 1'b1, 1'b1, 16'hFFC8, 4};
    tbl[4] = '{8'hFE, 8'hFF, 2'b00, 1'b1, 1'b0, 16'hFFFA, 1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; w = '0; prec = '0; a_signed = 1'b0; w_signed = 1'b0;
    #12;
    chk("reset_outputs", {12'd0, in_ready, out_valid, busy, 1'b0, p}, {12'd0, 4'b1000, 16'h0000});
    @(negedge clk); rst = 1'b0;

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      start_and_wait(tbl[t].a, tbl[t].w, tbl[t].prec, tbl[t].as_, tbl[t].ws_, lat);
      chk($sformatf("tbl%0d_p", t), 32'(p), 32'(tbl[t].exp_p));
      chk($sformatf("tbl%0d_lat", t), 32'(lat), 32'(tbl[t].exp_lat));
      chk($sformatf("tbl%0d_busy", t), {31'd0, busy}, 32'd1);
      release_done(t % 2);
    end

    // DONE stall: out_ready low 10 cycles with in_valid high must not re-accept.
    start_and_wait(8'h12, 8'h34, 2'b10, 1'b0, 1'b0, lat);
    ph = p;
    chk("stall_p", 32'(ph), 32'(16'h03A8));
    @(negedge clk);
    a = 8'h05; w = 8'h03; prec = 2'b01; a_signed = 1'b0; w_signed = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_state_%0d", k), {29'd0, in_ready, out_valid, busy}, 32'b011);
      chk($sformatf("stall_p_%0d", k), 32'(p), 32'(ph));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk("stall_release_idle", {29'd0, in_ready, out_valid, busy}, 32'b100);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("stall_next_accept", {29'd0, in_ready, out_valid, busy}, 32'b001);
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("stall_next_lat", 32'(lat), 32'd4);
    chk("stall_next_p", 32'(p), 32'(16'd15));
    release_done(0);

    // Reset during RUN cycle 7 of an 8-bit multiply.
    @(negedge clk);
    a = 8'h7F; w = 8'h81; prec = 2'b10; a_signed = 1'b1; w_signed = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin @(posedge clk); #1; end
    rst = 1'b1; #1;
    chk("abort_outputs", {12'd0, in_ready, out_valid, busy, 1'b0, p}, {12'd0, 4'b1000, 16'h0000});
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out_valid) chk("abort_no_out_valid", 32'(out_valid), 32'd0);
    end
    checks++;  // the 20-cycle watch above counts as one comparison
    run_op(8'h0B, 8'h0D, 2'b01, 1'b1, 1'b0, 0, "after_abort");

    // Random operations against the model.
    for (int t = 0; t < 40; t++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
